// File: rtl/press_classifier_pkg.sv
// Shared definitions for the push-button press classifier: state and event
// encodings plus the default timing constants used to decode last_evt.
package press_classifier_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PRESS1 = 2'b01,
    GAP    = 2'b10,
    HELD   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    EVT_NONE   = 2'b00,
    EVT_SHORT  = 2'b01,
    EVT_LONG   = 2'b10,
    EVT_DOUBLE = 2'b11
  } evt_t;

  // 500 ms long press and 250 ms double-click window at 50 MHz.
  localparam int unsigned LONG_N_DEF = 25_000_000;
  localparam int unsigned GAP_N_DEF  = 12_500_000;
  localparam int unsigned CW_DEF     = 25;

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button edges into short, long and double-click pulses,
// with a sticky last-event code. Single FSMD sharing one duration counter.
module press_classifier
  import press_classifier_pkg::*;
#(
  parameter int unsigned LONG_N = LONG_N_DEF,
  parameter int unsigned GAP_N  = GAP_N_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_level,
  input  logic       db_tick,
  output logic       short_tick,
  output logic       long_tick,
  output logic       double_tick,
  output logic [1:0] last_evt,
  output logic       busy
);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  evt_t            w_evt;
  evt_t            r_last;
  logic            r_short;
  logic            r_long;
  logic            r_double;
  logic            r_busy;
  logic            w_rise;
  logic            w_fall;

  // db_tick coincides with the last cycle of the old level.
  assign w_rise = db_tick & ~db_level;
  assign w_fall = db_tick &  db_level;

  always_comb begin
    w_next = r_state;
    w_evt  = EVT_NONE;
    case (r_state)
      IDLE: begin
        if (w_rise) w_next = PRESS1;
      end
      PRESS1: begin
        if (w_fall) begin
          w_next = GAP;
        end else if (r_cnt == CW'(LONG_N - 1)) begin
          w_next = HELD;
          w_evt  = EVT_LONG;
        end
      end
      GAP: begin
        if (w_rise) begin
          w_next = HELD;
          w_evt  = EVT_DOUBLE;
        end else if (r_cnt == CW'(GAP_N - 1)) begin
          w_next = IDLE;
          w_evt  = EVT_SHORT;
        end
      end
      HELD: begin
        if (w_fall) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_next != r_state) begin
      w_cnt_next = '0;
    end else if (r_state == PRESS1 || r_state == GAP) begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last   <= EVT_NONE;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_short  <= (w_evt == EVT_SHORT);
      r_long   <= (w_evt == EVT_LONG);
      r_double <= (w_evt == EVT_DOUBLE);
      r_busy   <= (w_next != IDLE);
      if (w_evt != EVT_NONE) r_last <= w_evt;
    end
  end

  assign short_tick  = r_short;
  assign long_tick   = r_long;
  assign double_tick = r_double;
  assign last_evt    = r_last;
  assign busy        = r_busy;

endmodule

// File: doc/press_classifier.md
# press_classifier

Classifies debounced push-button activity into short-press, long-press and double-click events. It sits directly downstream of the `debounce` stage and consumes that stage's `db_level` and `db_tick` outputs. It emits one-cycle event pulses plus a sticky last-event code for the control logic and display logic.

## Interface
- `LONG_N`, default 25_000_000: press duration in clock cycles that makes a long press (500 ms at 50 MHz).
- `GAP_N`, default 12_500_000: release window in clock cycles for a second press to count as a double click (250 ms).
- `CW`, default 25: counter width. It must satisfy 2^CW > max(LONG_N, GAP_N).
- `clk` input 1: system clock, single clock domain.
- `reset` input 1: asynchronous, active-low reset.
- `db_level` input 1: debounced level from `debounce`.
- `db_tick` input 1: one-cycle edge pulse from `debounce`.
- `short_tick` output 1: one-cycle pulse for a short single press.
- `long_tick` output 1: one-cycle pulse for a long press.
- `double_tick` output 1: one-cycle pulse for a double click.
- `last_evt` output 2: last event code. 00 = none, 01 = short, 10 = long, 11 = double.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- Edge decode follows from the upstream timing, where `db_tick` coincides with the last cycle of the old `db_level`.
  - rise = `db_tick` & ~`db_level`.
  - fall = `db_tick` & `db_level`.
- One CW-bit counter `cnt` is cleared on every state entry and increments each cycle in PRESS1 and GAP.
- IDLE:
  - On rise, go to PRESS1.
  - Ignore fall. This covers a button already held at reset release.
- PRESS1:
  - On fall, go to GAP. Fall has priority over timeout.
  - Otherwise, if cnt == LONG_N-1, go to HELD and pulse `long_tick`.
- GAP:
  - On rise, go to HELD and pulse `double_tick`. Rise has priority over timeout.
  - Otherwise, if cnt == GAP_N-1, go to IDLE and pulse `short_tick`.
- HELD:
  - On fall, go to IDLE.
  - Ignore rise.
  - No event is generated in HELD. A long hold after a double click does not produce `long_tick`.
- `last_evt` loads the code of each pulse in the same cycle the pulse asserts. It otherwise holds its value.
- At most one event pulse is high in any cycle.
- Unused state encodings recover to IDLE on the next clock edge with no pulse.

## Timing
- Reset values:
  - State IDLE, `cnt` = 0.
  - `short_tick`, `long_tick`, `double_tick`, `busy` all 0.
  - `last_evt` = 00.
  - Reset asserted mid-sequence aborts the sequence with no pulse.
- All outputs are registered, with no combinational path from inputs to outputs.
- Rise tick at cycle T with no fall: `long_tick` is high in cycle T+LONG_N+1 only. `busy` is high from T+1.
- Rise at T and fall at F, where F-T ≤ LONG_N: GAP is entered at F+1.
  - With no rise in cycles F+1..F+GAP_N, `short_tick` is high at F+GAP_N+1.
  - A rise at cycle R in F+1..F+GAP_N puts `double_tick` high at R+1.
- Fall landing exactly on the long-timeout cycle (F = T+LONG_N): the press is classified short.
- `busy` falls in the cycle after leaving HELD, or in the cycle `short_tick` asserts.
- `db_tick` held high continuously is illegal upstream behaviour. Each cycle it is high is treated as a separate edge.

## Structure
- The shared package holds:
  - The state encoding localparams IDLE/PRESS1/GAP/HELD (2 bits).
  - The event codes EVT_NONE/EVT_SHORT/EVT_LONG/EVT_DOUBLE.
  - The default timing constants, so display logic can decode `last_evt`.
- The block is one FSMD module: state and counter registers plus a next-state always block, the same style as `debounce`.
- No sub-module. The single shared counter does not justify one.
- Top level chains `debounce` → `press_classifier` per button.

## Test plan
Bench parameters: LONG_N = 8, GAP_N = 4, CW = 4. Edges are injected directly as `db_tick`/`db_level` pulses.
- Reset low during PRESS1 with cnt = 5, released 3 cycles later → no pulse, `busy` = 0, `last_evt` = 00, and the next rise starts a fresh count.
- Rise at cycle 10, fall at cycle 13, no further ticks → `short_tick` high at cycle 18 only, `last_evt` = 01, `busy` low at 18.
- Rise at 10, no fall → `long_tick` at 19 only, `last_evt` = 10. Fall at 30 → IDLE at 31 with no pulse.
- Rise at 10, fall at 12, rise at 15 → `double_tick` at 16, `last_evt` = 11. Hold 20 cycles → no `long_tick`.
- Boundary cases:
  - Rise at 10, fall exactly at 18 → classified short, `short_tick` at 23.
  - Rise at 10, fall at 12, rise exactly at 16 → `double_tick` at 17, no `short_tick`.
- Fall tick while IDLE right after reset → ignored, `busy` stays 0. A subsequent rise at cycle 20 with fall at 22 → `short_tick` at 27.
